// File: rtl/ddr2_v11_0_p0_sequencer_rom_loader_if.sv
// Byte-stream and ROM debug-port bundle between the sequencer ROM loader and its neighbours.
interface ddr2_v11_0_p0_sequencer_rom_loader_if #(
    parameter int unsigned ADDR_W = 12
);
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] rom_address;
    logic [3:0]        rom_byteenable;
    logic              rom_chipselect;
    logic              rom_write;
    logic              rom_debugaccess;
    logic [31:0]       rom_writedata;
    logic              rom_clken;
    logic [31:0]       rom_readdata;

    modport master (
        input  s_data, s_valid, rom_readdata,
        output s_ready, rom_address, rom_byteenable, rom_chipselect,
               rom_write, rom_debugaccess, rom_writedata, rom_clken
    );

    modport slave (
        output s_data, s_valid, rom_readdata,
        input  s_ready, rom_address, rom_byteenable, rom_chipselect,
               rom_write, rom_debugaccess, rom_writedata, rom_clken
    );
endinterface

// File: rtl/ddr2_v11_0_p0_sequencer_rom_loader.sv
// Packs a byte stream into 32-bit words, writes them into the sequencer ROM, reads the
// range back and compares checksums; holds the sequencer CPU in reset until verified.
module ddr2_v11_0_p0_sequencer_rom_loader #(
    parameter int unsigned ADDR_W            = 12,
    parameter bit          HOLD_UNTIL_LOADED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      word_count,
    ddr2_v11_0_p0_sequencer_rom_loader_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 seq_reset_n
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WRITE, S_VERIFY_RD, S_VERIFY_CHK, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [31:0]       word_q, word_d;
    logic [31:0]       wsum_q, wsum_d;
    logic [31:0]       rsum_q, rsum_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              last_word;

    logic              s_ready_q, s_ready_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [3:0]        rom_be_q, rom_be_d;
    logic              rom_cs_q, rom_cs_d;
    logic              rom_wr_q, rom_wr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              rom_clken_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              seq_rst_n_q, seq_rst_n_d;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        wsum_d  = wsum_q;
        rsum_d  = rsum_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        last_word = (idx_q == count_q - CNT_W'(1));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = '0;
                    bcnt_d  = '0;
                    word_d  = '0;
                    wsum_d  = '0;
                    rsum_d  = '0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    if (word_count > CNT_W'(DEPTH)) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (word_count == '0) begin
                        pass_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.s_valid && s_ready_q) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = bus.s_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wsum_d = wsum_q + word_q;
                if (last_word) begin
                    idx_d   = '0;
                    state_d = S_VERIFY_RD;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_VERIFY_RD: begin
                state_d = S_VERIFY_CHK;
            end
            S_VERIFY_CHK: begin
                rsum_d = rsum_q + bus.rom_readdata;
                if (last_word) begin
                    pass_d  = (rsum_d == wsum_q);
                    fail_d  = !pass_d;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = S_VERIFY_RD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the state being entered
        s_ready_d   = (state_d == S_LOAD);
        rom_wr_d    = (state_d == S_WRITE);
        rom_cs_d    = rom_wr_d || (state_d == S_VERIFY_RD);
        rom_be_d    = rom_wr_d ? 4'hF : 4'h0;
        rom_addr_d  = rom_cs_d ? (base_d + ADDR_W'(idx_d)) : '0;
        rom_wdata_d = rom_wr_d ? word_d : '0;
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        seq_rst_n_d = (state_d == S_IDLE) && (!HOLD_UNTIL_LOADED || pass_d);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            wsum_q      <= '0;
            rsum_q      <= '0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            s_ready_q   <= 1'b0;
            rom_addr_q  <= '0;
            rom_be_q    <= '0;
            rom_cs_q    <= 1'b0;
            rom_wr_q    <= 1'b0;
            rom_wdata_q <= '0;
            rom_clken_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            seq_rst_n_q <= !HOLD_UNTIL_LOADED;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            wsum_q      <= wsum_d;
            rsum_q      <= rsum_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            s_ready_q   <= s_ready_d;
            rom_addr_q  <= rom_addr_d;
            rom_be_q    <= rom_be_d;
            rom_cs_q    <= rom_cs_d;
            rom_wr_q    <= rom_wr_d;
            rom_wdata_q <= rom_wdata_d;
            rom_clken_q <= 1'b1;
            busy_q      <= busy_d;
            done_q      <= done_d;
            seq_rst_n_q <= seq_rst_n_d;
        end
    end

    assign bus.s_ready         = s_ready_q;
    assign bus.rom_address     = rom_addr_q;
    assign bus.rom_byteenable  = rom_be_q;
    assign bus.rom_chipselect  = rom_cs_q;
    assign bus.rom_write       = rom_wr_q;
    assign bus.rom_debugaccess = rom_wr_q;
    assign bus.rom_writedata   = rom_wdata_q;
    assign bus.rom_clken       = rom_clken_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign pass                = pass_q;
    assign fail                = fail_q;
    assign seq_reset_n         = seq_rst_n_q;
endmodule

// File: tb/tb_ddr2_v11_0_p0_sequencer_rom_loader.sv
// Bench for the sequencer ROM loader: ROM model with optional readback corruption,
// directed and randomized loads checked against a word-level reference.
module tb_ddr2_v11_0_p0_sequencer_rom_loader;
    localparam int unsigned ADDR_W = 12;
    localparam int          DEPTH  = 4096;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [12:0] word_count = '0;
    logic        busy, done, pass, fail, seq_reset_n;

    int n_tests = 0;
    int n_fail  = 0;

    ddr2_v11_0_p0_sequencer_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    ddr2_v11_0_p0_sequencer_rom_loader #(.ADDR_W(ADDR_W), .HOLD_UNTIL_LOADED(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .bus(bus), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .seq_reset_n(seq_reset_n)
    );

    always #5 clk = ~clk;

    // ROM model: one-cycle read latency, optional single-address readback corruption
    logic [31:0] mem [DEPTH];
    logic [7:0]  stim_bytes [$];
    logic [11:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [11:0] rd_addr_q [$];
    int          strobe_cnt = 0;
    int          wr_attr_err = 0;
    bit          corrupt_en = 1'b0;
    logic [11:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (bus.rom_chipselect || bus.rom_write || bus.rom_debugaccess || bus.rom_byteenable != 4'h0)
            strobe_cnt++;
        if (bus.rom_clken && bus.rom_chipselect) begin
            if (bus.rom_write) begin
                if (bus.rom_debugaccess) mem[bus.rom_address] <= bus.rom_writedata;
                if (bus.rom_byteenable != 4'hF || !bus.rom_debugaccess) wr_attr_err++;
                wr_addr_q.push_back(bus.rom_address);
                wr_data_q.push_back(bus.rom_writedata);
            end else begin
                bus.rom_readdata <= mem[bus.rom_address] ^
                    ((corrupt_en && bus.rom_address == corrupt_addr) ? 32'h1 : 32'h0);
                rd_addr_q.push_back(bus.rom_address);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'd0);
        chk({tag, "_cs"}, 64'(bus.rom_chipselect), 64'd0);
        chk({tag, "_wr"}, 64'(bus.rom_write), 64'd0);
        chk({tag, "_dbg"}, 64'(bus.rom_debugaccess), 64'd0);
        chk({tag, "_addr"}, 64'(bus.rom_address), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.rom_writedata), 64'd0);
        chk({tag, "_be"}, 64'(bus.rom_byteenable), 64'd0);
        chk({tag, "_clken"}, 64'(bus.rom_clken), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_fail"}, 64'(fail), 64'd0);
        chk({tag, "_seq_rst"}, 64'(seq_reset_n), 64'd0);
    endtask

    // One load from a negedge: start pulse, byte feed with optional stall/poke/abort, then checks
    task automatic run_load(input logic [11:0] base, input logic [12:0] cnt, input bit seq_bytes,
                            input int stall_at, input int stall_len, input bit poke,
                            input bit abort_rd, input bit exp_pass, input string tag);
        int nwords, nbytes, ptr, stalled, cycles, limit, exp_cycles, fails0;
        bit acc, poked;
        logic [31:0] exp_word, exp_sum, got_sum;
        nwords = (cnt > 13'd4096) ? 0 : int'(cnt);
        nbytes = 4 * nwords;
        stim_bytes.delete();
        for (int i = 0; i < nbytes; i++)
            stim_bytes.push_back(seq_bytes ? 8'(i + 1) : 8'($urandom_range(0, 255)));
        wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
        strobe_cnt = 0; wr_attr_err = 0;
        ptr = 0; stalled = 0; poked = 1'b0;
        exp_cycles = 1 + 7 * nwords + stall_len;
        limit = exp_cycles + 20;

        start = 1'b1; base_addr = base; word_count = cnt;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < limit) begin
            if (abort_rd && bus.rom_chipselect && !bus.rom_write) begin
                reset_n = 1'b0;
                bus.s_valid = 1'b0;
                @(negedge clk);
                chk_reset({tag, "_midrst"});
                reset_n = 1'b1;
                @(negedge clk);
                chk({tag, "_midrst_busy"}, 64'(busy), 64'd0);
                return;
            end
            if (ptr < nbytes && !(ptr == stall_at && stalled < stall_len)) begin
                bus.s_valid = 1'b1;
                bus.s_data  = stim_bytes[ptr];
            end else begin
                bus.s_valid = 1'b0;
                if (ptr == stall_at && stalled < stall_len) stalled++;
            end
            if (poke && !poked && stalled == 3) begin
                start = 1'b1; base_addr = ~base; word_count = 13'd5; poked = 1'b1;
            end
            acc = bus.s_valid && bus.s_ready;
            @(negedge clk);
            cycles++;
            start = 1'b0;
            if (acc) ptr++;
        end
        bus.s_valid = 1'b0;
        if (abort_rd) chk({tag, "_abort_reached"}, 64'd0, 64'd1);

        chk({tag, "_done_lat"}, 64'(cycles), 64'(exp_cycles));
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
        chk({tag, "_fail"}, 64'(fail), 64'(!exp_pass));
        chk({tag, "_busy_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_idle"}, 64'(busy), 64'd0);
        chk({tag, "_seq_rst"}, 64'(seq_reset_n), 64'(exp_pass));
        chk({tag, "_pass_hold"}, 64'(pass), 64'(exp_pass));

        chk({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(nwords));
        chk({tag, "_nrd"}, 64'(rd_addr_q.size()), 64'(nwords));
        chk({tag, "_wr_attr"}, 64'(wr_attr_err), 64'd0);
        if (nwords == 0) chk({tag, "_strobes"}, 64'(strobe_cnt), 64'd0);
        exp_sum = '0; got_sum = '0;
        fails0 = n_fail;
        for (int i = 0; i < nwords && i < wr_addr_q.size() && i < rd_addr_q.size(); i++) begin
            exp_word = {stim_bytes[4*i+3], stim_bytes[4*i+2], stim_bytes[4*i+1], stim_bytes[4*i]};
            exp_sum += exp_word;
            got_sum += wr_data_q[i];
            chk({tag, "_wr_addr"}, 64'(wr_addr_q[i]), 64'((int'(base) + i) % DEPTH));
            chk({tag, "_wr_data"}, 64'(wr_data_q[i]), 64'(exp_word));
            chk({tag, "_rd_addr"}, 64'(rd_addr_q[i]), 64'((int'(base) + i) % DEPTH));
            if (n_fail != fails0) break;
        end
        if (nwords > 0) chk({tag, "_wsum"}, 64'(got_sum), 64'(exp_sum));
    endtask

    initial begin
        int n, sat, slen;
        bit cen;
        logic [11:0] b;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        repeat (3) @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_clken", 64'(bus.rom_clken), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_seq", 64'(seq_reset_n), 64'd0);

        run_load(12'h000, 13'd2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b1, "basic");
        run_load(12'hFFF, 13'd2, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, "wrap");
        corrupt_en = 1'b1; corrupt_addr = 12'h001;
        run_load(12'h000, 13'd2, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0, "mismatch");
        corrupt_en = 1'b0;
        run_load(12'h123, 13'd4097, 1'b0, -1, 0, 1'b0, 1'b0, 1'b0, "range_hi");
        run_load(12'h123, 13'd0, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, "range_zero");
        run_load(12'h000, 13'd2, 1'b1, 2, 7, 1'b1, 1'b0, 1'b1, "stall");
        run_load(12'h010, 13'd3, 1'b0, -1, 0, 1'b0, 1'b1, 1'b0, "abort");
        run_load(12'h020, 13'd3, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, "fresh");

        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(1, 6);
            b = 12'($urandom_range(0, DEPTH - 1));
            cen = 1'($urandom_range(0, 1));
            corrupt_en = cen;
            corrupt_addr = 12'((int'(b) + $urandom_range(0, n - 1)) % DEPTH);
            if ($urandom_range(0, 1) == 1) begin
                sat  = 4 * $urandom_range(0, n - 1) + $urandom_range(1, 3);
                slen = $urandom_range(1, 5);
            end else begin
                sat = -1; slen = 0;
            end
            run_load(b, 13'(n), 1'b0, sat, slen, 1'b0, 1'b0, !cen, "rand");
        end
        corrupt_en = 1'b0;

        run_load(12'($urandom_range(0, DEPTH - 1)), 13'd4096, 1'b0, -1, 0, 1'b0, 1'b0, 1'b1, "full");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ddr2_v11_0_p0_sequencer_rom_loader.md
# ddr2_v11_0_p0_sequencer_rom_loader

Upstream loader for the DDR2 sequencer instruction ROM (4096 x 32, single-port, one-cycle read latency). It accepts a byte stream from the board-support host path, packs it into 32-bit words, writes them into the ROM through its debug write port, then reads the written range back and compares checksums. It holds the sequencer CPU in reset until a load has verified.

## Interface
Parameters:
- ADDR_W, 12, ROM word address width. Depth is 2^ADDR_W = 4096.
- HOLD_UNTIL_LOADED, 1. If 1, `seq_reset_n` stays low after reset until a passing load. If 0, it is low only while `busy`.

Ports:
- clk  in  1  clock for the loader and the ROM.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load. Ignored while `busy`.
- base_addr  in  12  first ROM word address. Sampled on `start`.
- word_count  in  13  number of words to load. Sampled on `start`. Valid range is 0..4096.
- s_data  in  8  stream byte.
- s_valid  in  1  `s_data` is valid.
- s_ready  out  1  the loader accepts a byte this cycle.
- rom_address  out  12  ROM address.
- rom_byteenable  out  4  ROM byte enables.
- rom_chipselect  out  1  ROM chip select.
- rom_write  out  1  ROM write strobe.
- rom_debugaccess  out  1  ROM debug access. Required high for a ROM write.
- rom_writedata  out  32  ROM write data.
- rom_clken  out  1  ROM clock enable.
- rom_readdata  in  32  ROM read data.
- busy  out  1  a load is in progress.
- done  out  1  one-cycle pulse at the end of a load.
- pass  out  1  result of the last load: checksums matched.
- fail  out  1  result of the last load: checksum mismatch or range error.
- seq_reset_n  out  1  reset to the sequencer CPU.

## Operation
- States and transitions:
  - IDLE: on `start`, go to LOAD.
  - LOAD: on the 4th byte accepted, go to WRITE.
  - WRITE: go to LOAD, or to VERIFY_RD after the last word.
  - VERIFY_RD then VERIFY_CHK: repeat once per word.
  - VERIFY_CHK: after the last word, go to DONE.
  - DONE: go to IDLE.
- On `start`:
  - Latch `base_addr` and `word_count`.
  - Clear the word index, byte counter, both checksums, `pass` and `fail`.
- Range check at start:
  - `word_count` > 4096: go to DONE, set `fail`=1, perform no ROM access.
  - `word_count` = 0: go to DONE, set `pass`=1, perform no ROM access.
- LOAD:
  - `s_ready`=1.
  - Each accepted byte (`s_valid` & `s_ready`) fills a byte lane of the word. Byte k goes to bits [8k+7:8k] (little-endian).
- WRITE (one cycle):
  - `rom_chipselect` = `rom_write` = `rom_debugaccess` = 1.
  - `rom_byteenable` = 4'hF.
  - `rom_address` = (base + index) mod 4096. The address wraps past 4095 to 0.
  - `rom_writedata` = the assembled word.
  - `wsum` += word, modulo 2^32.
  - index increments.
  - `s_ready`=0.
- VERIFY_RD:
  - `rom_chipselect`=1, `rom_write`=0.
  - `rom_address` = (base + index) mod 4096.
- VERIFY_CHK:
  - `rsum` += `rom_readdata`.
  - index increments.
- Last VERIFY_CHK: `pass` = (`rsum` including this word == `wsum`), `fail` = !`pass`.
- DONE: `done`=1 for one cycle. `pass`/`fail` hold until the next accepted `start`.
- `busy` = 1 in every state except IDLE.
- `seq_reset_n`:
  - Low while `busy`.
  - After DONE, high if `pass`.
  - With HOLD_UNTIL_LOADED=1: stays low after a failing load and after reset.
- `rom_clken` = 1 whenever `reset_n`=1.
- ROM outputs are 0 in every state other than the ones listed above.

## Timing
- Reset values (registered outputs):
  - `s_ready`, `rom_*` strobes, `rom_address`, `rom_writedata`, `rom_byteenable`, `busy`, `done`, `pass`, `fail`: all 0.
  - `rom_clken`: 0 while in reset.
  - `seq_reset_n`: 0 if HOLD_UNTIL_LOADED=1, otherwise 1.
- `start` at edge t: `s_ready`=1 from cycle t+1.
- Write throughput: 4 bytes then 1 write cycle, so 5 cycles per word with `s_valid` held high.
- The ROM read is unregistered-output: `rom_readdata` is valid in the cycle after VERIFY_RD.
- Verify costs 2 cycles per word.
- `done` is asserted exactly one cycle after the final VERIFY_CHK.
- `s_valid` low mid-word: stall. The partial word is kept and no timeout applies.
- Reset mid-load: all outputs return to reset values next cycle. ROM contents are left partially written. `pass`=0.
- `start` while `busy`: ignored, with no effect on state or latched values.

## Test plan
- Basic load:
  - Stimulus: `base_addr`=0, `word_count`=2, bytes 01 02 03 04 05 06 07 08.
  - Writes: 0x04030201 at address 0, then 0x08070605 at address 1.
  - Result: `wsum`=0x0C0A0806, `pass`=1, `seq_reset_n`→1.
  - `done` in cycle 1 + 10 + 4 after `start`.
- Address wrap:
  - Stimulus: `base_addr`=0xFFF, `word_count`=2.
  - Required: writes go to 0xFFF then 0x000. Readback addresses follow the same order.
- Mismatch:
  - Stimulus: the bench ROM model corrupts address 1 on readback (XOR 1).
  - Required: `fail`=1, `pass`=0, `seq_reset_n` stays 0.
- Range limits:
  - `word_count`=4097: `fail`=1, zero ROM strobes.
  - `word_count`=0: `pass`=1, `done` pulses, zero ROM strobes.
- Stall and ignored start:
  - Stimulus: `s_valid` dropped for 7 cycles after byte 2, plus a `start` pulse during LOAD.
  - Required: same written data as the basic load. The second `start` is ignored.
- Reset mid-operation:
  - Stimulus: `reset_n`=0 during VERIFY_RD.
  - Required: next cycle all outputs at reset values, `busy`=0.
  - A fresh `start` then completes normally.
